// File: rtl/bram_scanner.sv
`default_nettype none
// ============================================================================
// Module : bram_scanner
// Walks a block RAM read port over 0..FRAME_LEN-1 and emits the words as a
// valid/ready pixel stream through a 2-entry buffer.
// Rev    : 1.0
// ============================================================================
module bram_scanner #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = (1 << DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             loop,
    output logic             busy,
    output logic             done,
    output logic             re,
    output logic [DEPTH-1:0] addr_rd,
    input  logic [WIDTH-1:0] data_rd,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [WIDTH-1:0] pix_data,
    output logic [DEPTH-1:0] pix_addr,
    output logic             pix_last
);

    localparam logic [DEPTH-1:0] c_last_addr = DEPTH'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] addr_q, addr_d;
    logic             done_q, done_d;
    logic             inflight_q;
    logic [DEPTH-1:0] fl_addr_q;
    logic             fl_last_q;
    logic [1:0]       count_q, count_d;
    logic             rd_ptr_q, wr_ptr_q;
    logic [WIDTH-1:0] mem_data_q [2];
    logic [DEPTH-1:0] mem_addr_q [2];
    logic             mem_last_q [2];
    logic             pop;
    logic             at_last;

    assign pix_valid = (count_q != 2'd0);
    assign pop       = pix_valid & pix_ready;
    assign at_last   = (addr_q == c_last_addr);
    // Occupancy after this edge: the in-flight word lands, the head may leave.
    assign count_d   = count_q + {1'b0, inflight_q} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        re      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (count_d < 2'd2) begin
                    re     = 1'b1;
                    addr_d = at_last ? '0 : addr_q + DEPTH'(1);
                    if (at_last && !loop) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // No more reads are issued here, so the final pending word is the frame's last.
                if (pop && (count_q == 2'd1) && !inflight_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            fl_addr_q  <= '0;
            fl_last_q  <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            inflight_q <= re;
            if (re) begin
                fl_addr_q <= addr_q;
                fl_last_q <= at_last;
            end
            count_q <= count_d;
            if (inflight_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (inflight_q) begin
            mem_data_q[wr_ptr_q] <= data_rd;
            mem_addr_q[wr_ptr_q] <= fl_addr_q;
            mem_last_q[wr_ptr_q] <= fl_last_q;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign addr_rd  = addr_q;
    assign pix_data = pix_valid ? mem_data_q[rd_ptr_q] : '0;
    assign pix_addr = pix_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign pix_last = pix_valid & mem_last_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_bram_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_bram_scanner
// Directed bench for bram_scanner; three instances with FRAME_LEN 4, 256, 3.
// Rev    : 1.0
// ============================================================================
module tb_bram_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_s   [3];
    logic       loop_s    [3];
    logic       ready_s   [3];
    logic       busy_w    [3];
    logic       done_w    [3];
    logic       re_w      [3];
    logic [7:0] addr_w    [3];
    logic       valid_w   [3];
    logic [7:0] pdata_w   [3];
    logic [7:0] paddr_w   [3];
    logic       last_w    [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [7:0] ram_q = 8'h00;
        // RAM contents are RAM[i] = i + 0x10, one cycle read latency.
        always @(posedge clk) begin
            if (re_w[g]) ram_q <= addr_w[g] + 8'h10;
        end
        bram_scanner #(
            .WIDTH    (8),
            .DEPTH    (8),
            .FRAME_LEN((g == 0) ? 4 : ((g == 1) ? 256 : 3))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_s[g]),
            .loop     (loop_s[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .re       (re_w[g]),
            .addr_rd  (addr_w[g]),
            .data_rd  (ram_q),
            .pix_valid(valid_w[g]),
            .pix_ready(ready_s[g]),
            .pix_data (pdata_w[g]),
            .pix_addr (paddr_w[g]),
            .pix_last (last_w[g])
        );
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input int g, input string pfx);
        chk({pfx, "_busy"},  int'(busy_w[g]),  0);
        chk({pfx, "_done"},  int'(done_w[g]),  0);
        chk({pfx, "_re"},    int'(re_w[g]),    0);
        chk({pfx, "_raddr"}, int'(addr_w[g]),  0);
        chk({pfx, "_valid"}, int'(valid_w[g]), 0);
        chk({pfx, "_pdata"}, int'(pdata_w[g]), 0);
        chk({pfx, "_paddr"}, int'(paddr_w[g]), 0);
        chk({pfx, "_last"},  int'(last_w[g]),  0);
    endtask

    // One frame (or looped frames) with a reference model of order, occupancy and timing.
    // mode: 0 ready high, 1 ready pattern 1,0,0, 2 ready low for 10 cycles after start.
    task automatic stream(input int g, input int fl, input int mode, input int loop_frames,
                          input int spur, input bit pre, input bit chain, input string pfx);
        int exp_words = (loop_frames + 1) * fl;
        int words = 0, held = 0, inflight_m = 0, exp_idx = 0, iss_idx = 0;
        int lasts = 0, issued = 0, first_valid = -1, stall_reads = 0, occ;
        bit final_pop_prev = 1'b0, finished = 1'b0, rdy, pop;
        for (int k = 0; (k < exp_words * 3 + 40) && !finished; k++) begin
            @(negedge clk);
            start_s[g] = ((k == 0) && !pre) || (k == spur) || (chain && done_w[g]);
            loop_s[g]  = (lasts < loop_frames);
            case (mode)
                1:       rdy = ((k % 3) == 0);
                2:       rdy = (k > 10);
                default: rdy = 1'b1;
            endcase
            ready_s[g] = rdy;
            #1;
            pop = valid_w[g] && rdy;
            chk({pfx, "_valid"}, int'(valid_w[g]), int'(held != 0));
            chk({pfx, "_busy"},  int'(busy_w[g]),  ((k == 0) && !pre) ? 0 : int'(!final_pop_prev));
            chk({pfx, "_done"},  int'(done_w[g]),  int'(final_pop_prev));
            if (mode == 0 && first_valid >= 0 && words < exp_words)
                chk({pfx, "_gap"}, int'(valid_w[g]), 1);
            if (valid_w[g]) begin
                if (first_valid < 0) begin
                    first_valid = k;
                    chk({pfx, "_latency"}, k, pre ? 2 : 3);
                end
                chk({pfx, "_pdata"}, int'(pdata_w[g]), (exp_idx + 16) % 256);
                chk({pfx, "_paddr"}, int'(paddr_w[g]), exp_idx);
                chk({pfx, "_last"},  int'(last_w[g]),  int'(exp_idx == fl - 1));
                if (pop) begin
                    words++;
                    exp_idx = (exp_idx + 1) % fl;
                end
            end
            occ = held + inflight_m - (pop ? 1 : 0);
            chk({pfx, "_re_room"}, int'(re_w[g] && (occ >= 2)), 0);
            if (re_w[g]) begin
                chk({pfx, "_raddr"}, int'(addr_w[g]), iss_idx);
                if (iss_idx == fl - 1) lasts++;
                iss_idx = (iss_idx + 1) % fl;
                issued++;
                if (k <= 10) stall_reads++;
            end
            final_pop_prev = pop && (words == exp_words);
            held = held + inflight_m - (pop ? 1 : 0);
            inflight_m = re_w[g] ? 1 : 0;
            if (done_w[g]) finished = 1'b1;
        end
        chk({pfx, "_finished"}, int'(finished), 1);
        chk({pfx, "_words"},    words,  exp_words);
        chk({pfx, "_issued"},   issued, exp_words);
        if (mode == 2) chk({pfx, "_stall_reads"}, stall_reads, 2);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            loop_s[i]  = 1'b0;
            ready_s[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_zero(i, $sformatf("reset%0d", i));
        @(negedge clk);
        rst = 1'b0;

        // Basic 4-word frame, ready held high.
        stream(0, 4, 0, 0, -1, 1'b0, 1'b0, "t1");
        // Sink stalled for 10 cycles after start.
        stream(0, 4, 2, 0, -1, 1'b0, 1'b0, "t3");
        // Full 256-word frame with ready pattern 1,0,0.
        stream(1, 256, 1, 0, -1, 1'b0, 1'b0, "t2");
        // Looping 3-word frames: two loops then a final frame.
        stream(2, 3, 0, 2, -1, 1'b0, 1'b0, "t4");
        // Spurious start while busy, then start in the done cycle.
        stream(0, 4, 0, 0, 2, 1'b0, 1'b1, "t6a");
        stream(0, 4, 0, 0, -1, 1'b1, 1'b0, "t6b");
        repeat (3) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            #1;
            chk("t6_idle_busy", int'(busy_w[0]), 0);
            chk("t6_idle_re",   int'(re_w[0]),   0);
        end

        // Asynchronous reset mid-frame with a read in flight.
        @(negedge clk);
        start_s[1] = 1'b1;
        ready_s[1] = 1'b1;
        loop_s[1]  = 1'b0;
        @(negedge clk);
        start_s[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t5_pre_re", int'(re_w[1]), 1);
        @(posedge clk);
        #2;
        chk("t5_pre_valid", int'(valid_w[1]), 1);
        rst = 1'b1;
        #1;
        chk_zero(1, "t5_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stream(1, 256, 0, 0, -1, 1'b0, 1'b0, "t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no completion, expected finish before 300000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
